// File: rtl/seq_detect_ctrl_if.sv
// Bus bundle for seq_detect_ctrl: word input handshake, serial observation taps,
// per-word result handshake and cumulative counters.
interface seq_detect_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int HW = $clog2(WIDTH + 1);

    // valid/ready: a transfer happens in every cycle where valid and ready are both 1
    // at the rising edge; the source holds data stable while valid is high and ready is low.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             clear;
    logic             ser_bit;
    logic             ser_hit;
    logic             out_valid;
    logic             out_ready;
    logic [HW-1:0]    out_hits;
    logic [CNT_W-1:0] total_hits;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, ser_bit, ser_hit, out_valid, out_hits, total_hits, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, ser_bit, ser_hit, out_valid, out_hits, total_hits, busy, state_dbg
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Word-level run-length detector controller: serializes accepted words LSB-first into a
// run tracker and reports per-word and saturating cumulative hit counts.
module seq_detect_ctrl #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              reset,
    seq_detect_ctrl_if.slave io_bus
);
    localparam int HW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_word;
    logic [IW-1:0]    r_bit_idx;
    logic             r_last_bit;
    logic             r_last_vld;
    logic [RW-1:0]    r_run_len;
    logic [HW-1:0]    r_word_hits;
    logic [CNT_W-1:0] r_total;
    logic             r_ser_bit;
    logic             r_ser_hit;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_consume;
    logic          w_bit;
    logic          w_same;
    logic [RW-1:0] w_run_next;
    logic          w_hit;

    assign w_in_ready = (r_state == ST_IDLE) & ~reset;
    assign w_accept   = io_bus.in_valid & w_in_ready;
    assign w_consume  = (r_state == ST_SHIFT);
    assign w_bit      = r_word[r_bit_idx];
    assign w_same     = r_last_vld & (w_bit == r_last_bit);
    // Run length saturates at RUN_MAX so the hit keeps firing while the run continues.
    assign w_run_next = w_same ? ((r_run_len == RUN_MAX) ? RUN_MAX : r_run_len + RW'(1))
                               : RW'(1);
    assign w_hit      = w_consume & ~io_bus.clear & (w_run_next == RUN_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_SHIFT;
            ST_SHIFT: if (r_bit_idx == LAST_IDX) w_next = ST_DONE;
            ST_DONE:  if (io_bus.out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word      <= '0;
            r_bit_idx   <= '0;
            r_last_bit  <= 1'b0;
            r_last_vld  <= 1'b0;
            r_run_len   <= '0;
            r_word_hits <= '0;
            r_total     <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_hit   <= 1'b0;
        end else begin
            r_ser_hit <= w_hit;
            if (w_accept) begin
                r_word      <= io_bus.in_data;
                r_bit_idx   <= '0;
                r_word_hits <= '0;
            end
            if (w_consume) begin
                r_ser_bit <= w_bit;
                r_bit_idx <= r_bit_idx + IW'(1);
            end
            // Clear breaks the run; the bit consumed this cycle is not fed to the tracker.
            if (io_bus.clear) begin
                r_run_len   <= '0;
                r_last_vld  <= 1'b0;
                r_word_hits <= '0;
                r_total     <= '0;
            end else begin
                if (w_consume) begin
                    r_run_len  <= w_run_next;
                    r_last_bit <= w_bit;
                    r_last_vld <= 1'b1;
                end
                if (w_hit) begin
                    r_word_hits <= r_word_hits + HW'(1);
                    if (r_total != '1) r_total <= r_total + CNT_W'(1);
                end
            end
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.ser_bit    = r_ser_bit;
    assign io_bus.ser_hit    = r_ser_hit;
    assign io_bus.out_valid  = (r_state == ST_DONE);
    assign io_bus.out_hits   = r_word_hits;
    assign io_bus.total_hits = r_total;
    assign io_bus.busy       = (r_state != ST_IDLE);
    assign io_bus.state_dbg  = r_state;
endmodule
